// File: rtl/psum_acc_ctrl.sv
// PSUM path sequencer: pops OFIFO vectors, reads the PSUM row,
// writes the SFP result back (ACC and RELU passes).
module psum_acc_ctrl #(
  parameter int addr_bw = 11,
  parameter int cnt_bw  = 12
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_acc,
  input  logic               start_relu,
  input  logic [addr_bw-1:0] base_addr,
  input  logic [cnt_bw-1:0]  num_vec,
  input  logic               ofifo_valid,
  output logic               ofifo_rd,
  output logic               CEN_pmem,
  output logic               WEN_pmem,
  output logic [addr_bw-1:0] A_pmem,
  output logic               accum,
  output logic               busy,
  output logic               done
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    RD,
    WR,
    DONE
  } state_t;

  state_t state, state_n;

  logic [addr_bw-1:0] addr, addr_n;
  logic [cnt_bw-1:0]  remaining, rem_n;
  logic               accum_n;

  logic               ofifo_rd_n;
  logic               cen_n;
  logic               wen_n;
  logic [addr_bw-1:0] a_n;
  logic               busy_n;
  logic               done_n;

  always_comb begin
    state_n = state;
    addr_n  = addr;
    rem_n   = remaining;
    accum_n = accum;
    unique case (state)
      IDLE: begin
        if (start_acc || start_relu) begin
          addr_n  = base_addr;
          rem_n   = num_vec;
          accum_n = start_acc;
          if (num_vec == '0)
            state_n = DONE;
          else if (start_acc)
            state_n = WAIT;
          else
            state_n = RD;
        end
      end
      WAIT: begin
        if (ofifo_valid)
          state_n = RD;
      end
      RD: state_n = WR;
      WR: begin
        addr_n = addr + addr_bw'(1);
        rem_n  = remaining - cnt_bw'(1);
        // chain straight into the next read when another vector is ready
        if (remaining == cnt_bw'(1))
          state_n = DONE;
        else if (!accum || ofifo_valid)
          state_n = RD;
        else
          state_n = WAIT;
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // outputs are decoded from the next state and registered
  always_comb begin
    ofifo_rd_n = (state_n == WR) && accum_n;
    cen_n      = !(state_n inside {RD, WR});
    wen_n      = (state_n != WR);
    a_n        = (state_n inside {RD, WR}) ? addr_n : A_pmem;
    busy_n     = state_n inside {WAIT, RD, WR};
    done_n     = (state_n == DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      addr      <= '0;
      remaining <= '0;
      accum     <= 1'b0;
      ofifo_rd  <= 1'b0;
      CEN_pmem  <= 1'b1;
      WEN_pmem  <= 1'b1;
      A_pmem    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      addr      <= addr_n;
      remaining <= rem_n;
      accum     <= accum_n;
      ofifo_rd  <= ofifo_rd_n;
      CEN_pmem  <= cen_n;
      WEN_pmem  <= wen_n;
      A_pmem    <= a_n;
      busy      <= busy_n;
      done      <= done_n;
    end
  end

endmodule

// File: tb/tb_psum_acc_ctrl.sv
// Directed bench for psum_acc_ctrl with a small PSUM SRAM + SFP model.
module tb_psum_acc_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start_acc = 1'b0;
  logic        start_relu = 1'b0;
  logic [10:0] base_addr = '0;
  logic [11:0] num_vec = '0;
  logic        ofifo_valid = 1'b0;
  logic        ofifo_rd;
  logic        CEN_pmem;
  logic        WEN_pmem;
  logic [10:0] A_pmem;
  logic        accum;
  logic        busy;
  logic        done;

  logic [15:0] mem [0:2047];
  logic [15:0] vecs [0:3];
  logic [15:0] q = '0;
  int          pops = 0;
  int          writes = 0;
  int          accesses = 0;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  psum_acc_ctrl dut (
    .clk(clk),
    .reset(reset),
    .start_acc(start_acc),
    .start_relu(start_relu),
    .base_addr(base_addr),
    .num_vec(num_vec),
    .ofifo_valid(ofifo_valid),
    .ofifo_rd(ofifo_rd),
    .CEN_pmem(CEN_pmem),
    .WEN_pmem(WEN_pmem),
    .A_pmem(A_pmem),
    .accum(accum),
    .busy(busy),
    .done(done)
  );

  // one clock: SRAM read/write, SFP add or ReLU, FIFO pop
  task automatic tick();
    logic c, w, r, ac;
    logic [10:0] a;
    logic [15:0] v, sfp;
    c = CEN_pmem;
    w = WEN_pmem;
    r = ofifo_rd;
    ac = accum;
    a = A_pmem;
    v = vecs[pops[1:0]];
    sfp = ac ? q + v : (q[15] ? 16'h0000 : q);
    @(posedge clk);
    #1;
    if (!c) begin
      accesses++;
      if (w) q = mem[a];
      else begin
        mem[a] = sfp;
        writes++;
      end
    end
    if (r) pops++;
  endtask

  task automatic start(input logic a, input logic r,
                       input logic [10:0] b, input logic [11:0] n);
    start_acc = a;
    start_relu = r;
    base_addr = b;
    num_vec = n;
    tick();
    start_acc = 1'b0;
    start_relu = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({CEN_pmem, WEN_pmem, ofifo_rd, busy, done, accum} !== 6'b110000
        || A_pmem !== 11'd0) begin
      fails++;
      $display("FAIL reset_vals: got %b a=%0d want 110000 a=0",
               {CEN_pmem, WEN_pmem, ofifo_rd, busy, done, accum}, A_pmem);
    end
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      tests++;
      if ({CEN_pmem, WEN_pmem, ofifo_rd, busy, done} !== 5'b11000) begin
        fails++;
        $display("FAIL idle_%0d: got %b want 11000", i,
                 {CEN_pmem, WEN_pmem, ofifo_rd, busy, done});
      end
    end
  endtask

  task automatic test_acc();
    logic [10:0] ea [6] = '{11'd5, 11'd5, 11'd6, 11'd6, 11'd7, 11'd7};
    int p0;
    mem[5] = 16'd100;
    mem[6] = 16'hFFF0;
    mem[7] = 16'd7;
    vecs[pops[1:0]] = 16'd10;
    vecs[2'(pops + 1)] = 16'd20;
    vecs[2'(pops + 2)] = 16'd30;
    p0 = pops;
    ofifo_valid = 1'b1;
    start(1'b1, 1'b0, 11'd5, 12'd3);
    tests++;
    if ({CEN_pmem, WEN_pmem, ofifo_rd, busy, accum} !== 5'b11011) begin
      fails++;
      $display("FAIL acc_wait: got %b want 11011",
               {CEN_pmem, WEN_pmem, ofifo_rd, busy, accum});
    end
    tick();
    for (int i = 0; i < 6; i++) begin
      tests++;
      if (A_pmem !== ea[i] || CEN_pmem !== 1'b0
          || WEN_pmem !== (i % 2 == 0) || ofifo_rd !== (i % 2 == 1)) begin
        fails++;
        $display("FAIL acc_seq_%0d: got a=%0d cen=%b wen=%b rd=%b want a=%0d",
                 i, A_pmem, CEN_pmem, WEN_pmem, ofifo_rd, ea[i]);
      end
      tick();
    end
    chk("acc_done", {done, busy, CEN_pmem}, 3'b101);
    tick();
    chk("acc_done_pulse", done, 1'b0);
    chk("acc_row5", mem[5], 16'd110);
    chk("acc_row6", mem[6], 16'd4);
    chk("acc_row7", mem[7], 16'd37);
    chk("acc_pops", pops - p0, 3);
    ofifo_valid = 1'b0;
  endtask

  task automatic test_stall();
    int p0;
    mem[10] = 16'd1;
    mem[11] = 16'd2;
    vecs[pops[1:0]] = 16'd5;
    vecs[2'(pops + 1)] = 16'd6;
    p0 = pops;
    ofifo_valid = 1'b0;
    start(1'b1, 1'b0, 11'd10, 12'd2);
    for (int v = 0; v < 2; v++) begin
      for (int i = 0; i < 4; i++) begin
        tests++;
        if ({CEN_pmem, ofifo_rd, busy} !== 3'b101) begin
          fails++;
          $display("FAIL stall_%0d_%0d: got %b want 101", v, i,
                   {CEN_pmem, ofifo_rd, busy});
        end
        tick();
      end
      ofifo_valid = 1'b1;
      tick();
      chk("stall_rd", {CEN_pmem, WEN_pmem, A_pmem}, {2'b01, 11'(10 + v)});
      ofifo_valid = 1'b0;
      tick();
      chk("stall_wr", {CEN_pmem, WEN_pmem, ofifo_rd}, 3'b001);
      tick();
    end
    chk("stall_done", done, 1'b1);
    tick();
    chk("stall_pops", pops - p0, 2);
    chk("stall_row10", mem[10], 16'd6);
    chk("stall_row11", mem[11], 16'd8);
  endtask

  task automatic test_relu();
    logic [10:0] ea [6] = '{11'd2046, 11'd2046, 11'd2047, 11'd2047, 11'd0, 11'd0};
    int p0;
    mem[2046] = 16'hFFFB;
    mem[2047] = 16'd9;
    mem[0] = 16'h8001;
    p0 = pops;
    start(1'b0, 1'b1, 11'd2046, 12'd3);
    chk("relu_accum", accum, 1'b0);
    for (int i = 0; i < 6; i++) begin
      tests++;
      if (A_pmem !== ea[i] || busy !== 1'b1 || ofifo_rd !== 1'b0
          || WEN_pmem !== (i % 2 == 0)) begin
        fails++;
        $display("FAIL relu_seq_%0d: got a=%0d busy=%b rd=%b wen=%b want a=%0d",
                 i, A_pmem, busy, ofifo_rd, WEN_pmem, ea[i]);
      end
      tick();
    end
    chk("relu_done7", {done, busy}, 2'b10);
    tick();
    chk("relu_row2046", mem[2046], 16'd0);
    chk("relu_row2047", mem[2047], 16'd9);
    chk("relu_row0", mem[0], 16'd0);
    chk("relu_pops", pops - p0, 0);
  endtask

  task automatic test_both();
    int p0, w0, dcnt;
    mem[20] = 16'd50;
    vecs[pops[1:0]] = 16'd3;
    p0 = pops;
    w0 = writes;
    dcnt = 0;
    ofifo_valid = 1'b1;
    start(1'b1, 1'b1, 11'd20, 12'd1);
    chk("both_accum", {accum, busy}, 2'b11);
    start(1'b0, 1'b1, 11'd40, 12'd5);
    for (int i = 0; i < 12; i++) begin
      if (done) dcnt++;
      tick();
    end
    chk("both_done_once", dcnt, 1);
    chk("both_writes", writes - w0, 1);
    chk("both_pops", pops - p0, 1);
    chk("both_row20", mem[20], 16'd53);
    chk("both_idle", {busy, accum}, 2'b01);
    ofifo_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    int a0;
    mem[100] = 16'd1;
    mem[101] = 16'd2;
    vecs[pops[1:0]] = 16'd1;
    vecs[2'(pops + 1)] = 16'd1;
    ofifo_valid = 1'b1;
    start(1'b1, 1'b0, 11'd100, 12'd4);
    repeat (4) tick();
    chk("mid_in_wr2", {CEN_pmem, WEN_pmem, A_pmem}, {2'b00, 11'd101});
    #3 reset = 1'b0;
    #1;
    tests++;
    if ({CEN_pmem, WEN_pmem, ofifo_rd, busy, done, accum} !== 6'b110000
        || A_pmem !== 11'd0) begin
      fails++;
      $display("FAIL mid_async: got %b a=%0d want 110000 a=0",
               {CEN_pmem, WEN_pmem, ofifo_rd, busy, done, accum}, A_pmem);
    end
    ofifo_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    a0 = accesses;
    repeat (3) tick();
    chk("mid_quiet", {done, busy, CEN_pmem}, 3'b001);
    start(1'b0, 1'b1, 11'd300, 12'd0);
    chk("zero_done", {done, busy, CEN_pmem, WEN_pmem}, 4'b1011);
    tick();
    chk("zero_pulse", done, 1'b0);
    chk("zero_no_access", accesses - a0, 0);
  endtask

  initial begin
    test_reset();
    test_acc();
    test_stall();
    test_relu();
    test_both();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
